// File: rtl/simt_warp_stack.sv
// Multi-warp SIMT reconvergence stack: per-warp {sync, resume, mask} stacks with push/divergent push/pop.
// Optional automatic pop on reaching the top sync PC is enabled by defining SIMT_AUTO_RECONV_EN.
module simt_warp_stack #(
    parameter int unsigned WARPS   = 2,
    parameter int unsigned THREADS = 4,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned WORD_W  = 32
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [((WARPS > 1) ? $clog2(WARPS) : 1)-1:0] warp_sel,
    input  logic [1:0]                        push_en,
    input  logic                              pop_en,
    input  logic [WORD_W-1:0]                 new_sync,
    input  logic [WORD_W-1:0]                 new_addr,
    input  logic [THREADS-1:0]                new_mask,
    input  logic [WORD_W-1:0]                 alt_addr,
    input  logic [THREADS-1:0]                alt_mask,
    input  logic [WORD_W-1:0]                 pc_in,
    input  logic                              pc_valid,
    output logic [WORD_W-1:0]                 cur_sync,
    output logic [WORD_W-1:0]                 cur_addr,
    output logic [THREADS-1:0]                cur_mask,
    output logic [$clog2(DEPTH+1)-1:0]        depth,
    output logic                              is_empty,
    output logic                              is_full,
    output logic                              overflow,
    output logic                              underflow,
    output logic                              reconv
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WORD_W-1:0]  syncMem [WARPS][DEPTH];
    logic [WORD_W-1:0]  addrMem [WARPS][DEPTH];
    logic [THREADS-1:0] maskMem [WARPS][DEPTH];
    logic [CNT_W-1:0]   depthR  [WARPS];

    logic             selValid;
    logic [CNT_W-1:0] selDepth;
    logic [IDX_W-1:0] topIdx;
    logic             autoPop;
    logic             popReq;
    logic             popTaken;
    logic [1:0]       pushCnt;
    logic [CNT_W:0]   postPop;
    logic [CNT_W:0]   freeSlots;
    logic [CNT_W:0]   newDepth;
    logic [IDX_W-1:0] wrIdxA;
    logic [IDX_W-1:0] wrIdxB;
    logic             ovfC;
    logic             udfC;
    logic             commit;

    // Readout of the selected warp; an out-of-range warp reads as empty.
    always_comb begin
        selValid = 32'(warp_sel) < WARPS;
        selDepth = selValid ? depthR[warp_sel] : '0;
        topIdx   = IDX_W'(selDepth - CNT_W'(1));
        is_empty = (selDepth == '0);
        is_full  = (selDepth == CNT_W'(DEPTH));
        depth    = selDepth;
        cur_sync = '0;
        cur_addr = '0;
        cur_mask = '1;
        if (!is_empty) begin
            cur_sync = syncMem[warp_sel][topIdx];
            cur_addr = addrMem[warp_sel][topIdx];
            cur_mask = maskMem[warp_sel][topIdx];
        end
    end

`ifdef SIMT_AUTO_RECONV_EN
    assign autoPop = pc_valid && selValid && !is_empty && (pc_in == cur_sync);
`else
    logic unusedPc;
    assign unusedPc = ^{pc_in, pc_valid};
    assign autoPop  = 1'b0;
`endif

    // Command decode: pop is applied first, free-slot check uses the post-pop depth.
    always_comb begin
        popReq    = pop_en | autoPop;
        popTaken  = popReq && !is_empty;
        pushCnt   = (push_en == 2'b01) ? 2'd1 : (push_en == 2'b10) ? 2'd2 : 2'd0;
        postPop   = {1'b0, selDepth} - (CNT_W+1)'(popTaken);
        freeSlots = (CNT_W+1)'(DEPTH) - postPop;
        newDepth  = postPop + (CNT_W+1)'(pushCnt);
        wrIdxA    = IDX_W'(postPop);
        wrIdxB    = IDX_W'(postPop + (CNT_W+1)'(1));
        ovfC      = selValid && ((CNT_W+1)'(pushCnt) > freeSlots);
        commit    = selValid && !ovfC;
        udfC      = commit && popReq && is_empty;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned w = 0; w < WARPS; w++) begin
                depthR[w] <= '0;
            end
            overflow  <= 1'b0;
            underflow <= 1'b0;
            reconv    <= 1'b0;
        end else begin
            overflow  <= ovfC;
            underflow <= udfC;
            reconv    <= commit && autoPop;
            if (commit) begin
                depthR[warp_sel] <= CNT_W'(newDepth);
            end
        end
    end

    // Entry storage carries no reset; contents below depth are never observed.
    always_ff @(posedge CLK) begin
        if (!RST && commit && (pushCnt != 2'd0)) begin
            syncMem[warp_sel][wrIdxA] <= new_sync;
            addrMem[warp_sel][wrIdxA] <= new_addr;
            maskMem[warp_sel][wrIdxA] <= new_mask;
        end
        if (!RST && commit && (pushCnt == 2'd2)) begin
            syncMem[warp_sel][wrIdxB] <= new_sync;
            addrMem[warp_sel][wrIdxB] <= alt_addr;
            maskMem[warp_sel][wrIdxB] <= alt_mask;
        end
    end

endmodule

// File: tb/tb_simt_warp_stack.sv
// Directed self-checking bench for simt_warp_stack (WARPS=2, THREADS=4, DEPTH=8, WORD_W=32).
module tb_simt_warp_stack;

    logic        CLK = 1'b0;
    logic        RST;
    logic [0:0]  warp_sel;
    logic [1:0]  push_en;
    logic        pop_en;
    logic [31:0] new_sync, new_addr, alt_addr, pc_in;
    logic [3:0]  new_mask, alt_mask;
    logic        pc_valid;
    logic [31:0] cur_sync, cur_addr;
    logic [3:0]  cur_mask;
    logic [3:0]  depth;
    logic        is_empty, is_full, overflow, underflow, reconv;

    int checks = 0;
    int failures = 0;

    simt_warp_stack #(.WARPS(2), .THREADS(4), .DEPTH(8), .WORD_W(32)) dut (
        .CLK(CLK), .RST(RST), .warp_sel(warp_sel), .push_en(push_en), .pop_en(pop_en),
        .new_sync(new_sync), .new_addr(new_addr), .new_mask(new_mask),
        .alt_addr(alt_addr), .alt_mask(alt_mask), .pc_in(pc_in), .pc_valid(pc_valid),
        .cur_sync(cur_sync), .cur_addr(cur_addr), .cur_mask(cur_mask), .depth(depth),
        .is_empty(is_empty), .is_full(is_full), .overflow(overflow),
        .underflow(underflow), .reconv(reconv)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        push_en  = 2'b00;
        pop_en   = 1'b0;
        pc_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; warp_sel = 1'b0; idle();
        new_sync = '0; new_addr = '0; new_mask = '0; alt_addr = '0; alt_mask = '0; pc_in = '0;
        tick(); tick();
        RST = 1'b0;
        tick();

        // Reset state
        chk("rst_depth", 64'(depth), 64'd0);
        chk("rst_empty", 64'(is_empty), 64'd1);
        chk("rst_full", 64'(is_full), 64'd0);
        chk("rst_mask", 64'(cur_mask), 64'hF);
        chk("rst_sync", 64'(cur_sync), 64'd0);
        chk("rst_pulses", 64'({overflow, underflow, reconv}), 64'd0);

        // Divergent push on warp 0
        warp_sel = 1'b0; push_en = 2'b10;
        new_sync = 32'h40; new_addr = 32'h10; new_mask = 4'b0011;
        alt_addr = 32'h20; alt_mask = 4'b1100;
        tick(); idle();
        chk("div_depth", 64'(depth), 64'd2);
        chk("div_sync", 64'(cur_sync), 64'h40);
        chk("div_addr", 64'(cur_addr), 64'h20);
        chk("div_mask", 64'(cur_mask), 64'hC);
        warp_sel = 1'b1; #1;
        chk("w1_empty", 64'(is_empty), 64'd1);
        chk("w1_mask", 64'(cur_mask), 64'hF);

        // Fill warp 1 to capacity
        for (int i = 0; i < 8; i++) begin
            push_en = 2'b01; new_sync = 32'h100 + 32'(i);
            new_addr = 32'h200 + 32'(i); new_mask = 4'(i);
            tick();
        end
        idle();
        chk("fill_depth", 64'(depth), 64'd8);
        chk("fill_full", 64'(is_full), 64'd1);
        chk("fill_top", 64'(cur_addr), 64'h207);
        push_en = 2'b01; new_addr = 32'hDEAD;
        tick(); idle();
        chk("ovf_pulse", 64'(overflow), 64'd1);
        chk("ovf_depth", 64'(depth), 64'd8);
        chk("ovf_top", 64'(cur_addr), 64'h207);
        tick();
        chk("ovf_clear", 64'(overflow), 64'd0);
        // Pop + push at full replaces the top
        push_en = 2'b01; pop_en = 1'b1; new_sync = 32'h333; new_addr = 32'h300; new_mask = 4'b0101;
        tick(); idle();
        chk("pp_full_depth", 64'(depth), 64'd8);
        chk("pp_full_top", 64'({cur_sync, cur_addr[15:0], 12'h0, cur_mask}), {32'h333, 16'h300, 12'h0, 4'h5});
        chk("pp_full_ovf", 64'(overflow), 64'd0);
        // Pop + divergent push at full: one free slot is not enough, pop discarded too
        push_en = 2'b10; pop_en = 1'b1;
        tick(); idle();
        chk("ppd_ovf", 64'(overflow), 64'd1);
        chk("ppd_depth", 64'(depth), 64'd8);
        chk("ppd_top", 64'(cur_addr), 64'h300);

        // Drain warp 0 and underflow
        warp_sel = 1'b0; pop_en = 1'b1;
        tick();
        chk("pop1_depth", 64'(depth), 64'd1);
        chk("pop1_top", 64'({cur_addr, 28'h0, cur_mask}), {32'h10, 28'h0, 4'h3});
        tick(); idle();
        chk("pop2_empty", 64'(is_empty), 64'd1);
        chk("pop2_udf", 64'(underflow), 64'd0);
        pop_en = 1'b1;
        tick(); idle();
        chk("udf_pulse", 64'(underflow), 64'd1);
        chk("udf_depth", 64'(depth), 64'd0);
        tick();
        chk("udf_clear", 64'(underflow), 64'd0);
        pop_en = 1'b1; push_en = 2'b01; new_sync = 32'h40; new_addr = 32'h50; new_mask = 4'b0111;
        tick(); idle();
        chk("udf_push_pulse", 64'(underflow), 64'd1);
        chk("udf_push_depth", 64'(depth), 64'd1);
        chk("udf_push_top", 64'(cur_addr), 64'h50);

        // Reconvergence: top sync 0x80 reached
        push_en = 2'b01; new_sync = 32'h80; new_addr = 32'h60; new_mask = 4'b0001;
        tick(); idle();
        chk("rc_pre_depth", 64'(depth), 64'd2);
        pc_in = 32'h80; pc_valid = 1'b1;
        tick(); idle();
`ifdef SIMT_AUTO_RECONV_EN
        chk("rc_depth", 64'(depth), 64'd1);
        chk("rc_pulse", 64'(reconv), 64'd1);
`else
        chk("rc_depth", 64'(depth), 64'd2);
        chk("rc_pulse", 64'(reconv), 64'd0);
`endif
        push_en = 2'b01; new_sync = 32'h90; new_addr = 32'h70; new_mask = 4'b0010;
        tick(); idle();
        pc_in = 32'h90; pc_valid = 1'b1; pop_en = 1'b1;
        tick(); idle();
`ifdef SIMT_AUTO_RECONV_EN
        chk("rcpop_depth", 64'(depth), 64'd1);
        chk("rcpop_sync", 64'(cur_sync), 64'h40);
        chk("rcpop_pulse", 64'(reconv), 64'd1);
`else
        chk("rcpop_depth", 64'(depth), 64'd2);
        chk("rcpop_sync", 64'(cur_sync), 64'h80);
        chk("rcpop_pulse", 64'(reconv), 64'd0);
`endif
        tick();
        chk("rc_clear", 64'(reconv), 64'd0);

        // Reset during an overflowing divergent push on full warp 1
        warp_sel = 1'b1; #1;
        chk("pre_rst_full", 64'(is_full), 64'd1);
        RST = 1'b1; push_en = 2'b10;
        tick(); idle(); RST = 1'b0;
        chk("rst_cmd_depth", 64'(depth), 64'd0);
        chk("rst_cmd_pulses", 64'({overflow, underflow, reconv}), 64'd0);
        warp_sel = 1'b0; #1;
        chk("rst_w0_depth", 64'(depth), 64'd0);
        chk("rst_w0_mask", 64'(cur_mask), 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
